// File: rtl/pipeline_adder_arbiter.sv
// pipeline_adder_arbiter: round-robin sharing of one fixed-latency pipeline_adder
// datapath between two requesters. A tag shadow pipe follows each op, and results
// are buffered in a credit-protected FIFO, because the datapath cannot stall.
module pipeline_adder_arbiter #(
  parameter int WIDTH   = 5,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [5*WIDTH-1:0] req0_ops,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [5*WIDTH-1:0] req1_ops,
  output logic [WIDTH-1:0]   dp_a,
  output logic [WIDTH-1:0]   dp_b,
  output logic [WIDTH-1:0]   dp_c,
  output logic [WIDTH-1:0]   dp_d,
  output logic [WIDTH-1:0]   dp_e,
  input  logic [WIDTH-1:0]   dp_s,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_tag,
  output logic               busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] inf_t;
  typedef struct packed {
    logic             tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [1:0][5*WIDTH-1:0] ops;
  logic [5*WIDTH-1:0]      sel_ops;
  logic                    prio;
  logic                    issue_ok;
  logic                    grant_any;
  logic                    grant_idx;
  logic [LATENCY-1:0]      v_pipe;
  logic [LATENCY-1:0]      tag_pipe;
  inf_t                    inflight;
  entry_t                  mem [DEPTH];
  ptr_t                    wr_ptr;
  ptr_t                    rd_ptr;
  cnt_t                    count;
  logic                    push;
  logic                    pop;

  assign ops = {req1_ops, req0_ops};

  // number of ops currently travelling through the datapath
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + inf_t'(v_pipe[i]);
  end

  // credit ignores a same-cycle pop, so every issued op is guaranteed a FIFO slot
  assign issue_ok = (int'(count) + int'(inflight)) < DEPTH;

  // round-robin grant: pointer decides only when both requesters are valid
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (!reset && issue_ok) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_idx = prio;
      end else if (req0_valid) begin
        grant_any = 1'b1;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_idx;
  assign req1_ready = grant_any &  grant_idx;
  assign sel_ops    = grant_any ? ops[grant_idx] : '0;
  assign {dp_a, dp_b, dp_c, dp_d, dp_e} = sel_ops;

  // priority pointer moves to the loser after every grant
  always_ff @(posedge clk) begin
    if (reset)          prio <= 1'b0;
    else if (grant_any) prio <= ~grant_idx;
  end

  // tag shadow pipe, aligned with the datapath latency
  always_ff @(posedge clk) begin
    if (reset) begin
      v_pipe   <= '0;
      tag_pipe <= '0;
    end else begin
      v_pipe[0]   <= grant_any;
      tag_pipe[0] <= grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
        v_pipe[i]   <= v_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign push      = v_pipe[LATENCY-1];
  assign res_valid = !reset && (count != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = mem[rd_ptr].data;
  assign res_tag   = mem[rd_ptr].tag;
  assign busy      = (inflight != '0) || (count != '0);

  // result storage; content needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{tag: tag_pipe[LATENCY-1], data: dp_s};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (push && !pop)      count <= count + cnt_t'(1);
      else if (!push && pop) count <= count - cnt_t'(1);
    end
  end

  // the credit rule makes an overflowing push impossible
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && count == cnt_t'(DEPTH)));
  end
endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Bench for pipeline_adder_arbiter: behavioural datapath plus an issue-order
// scoreboard with credit = ops accepted minus results consumed.
module tb_pipeline_adder_arbiter;
  localparam int W     = 5;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int OW    = 5 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_ops, req1_ops;
  logic [W-1:0]  dp_a, dp_b, dp_c, dp_d, dp_e, dp_s;
  logic          res_valid, res_ready, res_tag, busy;
  logic [W-1:0]  res_data;
  int            checks = 0;
  int            failures = 0;

  pipeline_adder_arbiter #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ops(req0_ops),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ops(req1_ops),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_e(dp_e), .dp_s(dp_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // two-stage datapath stand-in with its own reset
  logic [W-1:0] s1_ab, s1_cd, s1_e, s2;
  always @(posedge clk) begin
    if (reset) begin
      s1_ab <= '0; s1_cd <= '0; s1_e <= '0; s2 <= '0;
    end else begin
      s1_ab <= dp_a + dp_b;
      s1_cd <= dp_c + dp_d;
      s1_e  <= dp_e;
      s2    <= (s1_ab - s1_cd) & s1_e;
    end
  end
  assign dp_s = s2;

  // reference model state
  typedef struct { logic [W-1:0] data; logic tag; int vis; } exp_t;
  exp_t          expq[$];
  int            outstanding = 0;
  int            cyc = 0;
  logic          ptr = 1'b0;
  logic          m_any, m_idx, m_rv, m_tag;
  logic [W-1:0]  m_data;
  logic [OW-1:0] m_dp;

  function automatic logic [W-1:0] ref_sum(input logic [OW-1:0] o);
    int a, b, c, d, e;
    a = int'(o[5*W-1:4*W]); b = int'(o[4*W-1:3*W]); c = int'(o[3*W-1:2*W]);
    d = int'(o[2*W-1:W]);   e = int'(o[W-1:0]);
    return W'((a + b - c - d) & e);
  endfunction

  // settle inputs and compute what the block must show this cycle
  task automatic predict();
    #1;
    m_any = 1'b0;
    m_idx = 1'b0;
    if (!reset && outstanding < DEPTH) begin
      if (req0_valid && req1_valid) begin m_any = 1'b1; m_idx = ptr; end
      else if (req0_valid) m_any = 1'b1;
      else if (req1_valid) begin m_any = 1'b1; m_idx = 1'b1; end
    end
    m_dp   = !m_any ? '0 : (m_idx ? req1_ops : req0_ops);
    m_rv   = !reset && expq.size() > 0 && expq[0].vis <= cyc;
    m_data = m_rv ? expq[0].data : '0;
    m_tag  = m_rv ? expq[0].tag : 1'b0;
  endtask

  // advance one clock and update the model from this cycle's transfers
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      outstanding = 0; ptr = 1'b0; expq.delete();
    end else begin
      if (m_rv && res_ready) begin void'(expq.pop_front()); outstanding--; end
      if (m_any) begin
        expq.push_back('{ref_sum(m_dp), m_idx, cyc + LAT + 1});
        outstanding++;
        ptr = ~m_idx;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    predict(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    req0_ops = OW'($urandom); req1_ops = OW'($urandom);
    for (int i = 0; i < 2; i++) begin
      predict();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready: got %b%b expected 00", req1_ready, req0_ready);
      end
      checks++;
      if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++;
      if ({dp_a, dp_b, dp_c, dp_d, dp_e} !== '0) begin
        failures++; $display("FAIL reset_dp: got %h expected 0", {dp_a, dp_b, dp_c, dp_d, dp_e});
      end
      tick();
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    predict();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL post_reset_res_valid: got %b expected 0", res_valid); end
    tick();
  endtask

  task automatic test_single(input logic who, input logic [W-1:0] a, b, c, d, e,
                             input logic [W-1:0] exp_s);
    int lat;
    bit seen;
    seen = 1'b0; lat = 0;
    res_ready = 1'b1;
    req0_ops = {a, b, c, d, e}; req1_ops = {a, b, c, d, e};
    req0_valid = ~who; req1_valid = who;
    predict();
    checks++;
    if (req0_ready !== ~who || req1_ready !== who) begin
      failures++; $display("FAIL single_ready: got %b%b for requester %0d", req1_ready, req0_ready, who);
    end
    checks++;
    if ({dp_a, dp_b, dp_c, dp_d, dp_e} !== {a, b, c, d, e}) begin
      failures++; $display("FAIL single_dp: got %h expected %h", {dp_a, dp_b, dp_c, dp_d, dp_e}, {a, b, c, d, e});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      predict();
      if (res_valid === 1'b1 && !seen) begin
        seen = 1'b1; lat = i;
        checks++;
        if (res_data !== exp_s || res_tag !== who) begin
          failures++; $display("FAIL single_result: got %0d/tag%b expected %0d/tag%b", res_data, res_tag, exp_s, who);
        end
      end
      tick();
    end
    checks++;
    if (!seen || lat != LAT + 1) begin
      failures++; $display("FAIL single_latency: got %0d (seen=%0d) expected %0d", lat, seen, LAT + 1);
    end
    predict();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_fairness();
    int pops;
    pops = 0;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req0_valid = (i < 8); req1_valid = (i < 8);
      req0_ops = OW'($urandom); req1_ops = OW'($urandom);
      predict();
      if (i < 8) begin
        checks++;
        if (req0_ready !== 1'(i % 2 == 0) || req1_ready !== 1'(i % 2 == 1)) begin
          failures++; $display("FAIL fair_grant: cycle %0d got %b%b", i, req1_ready, req0_ready);
        end
      end
      checks++;
      if (res_valid !== m_rv) begin failures++; $display("FAIL fair_res_valid: got %b expected %b", res_valid, m_rv); end
      if (m_rv) begin
        checks++;
        if (res_data !== m_data || res_tag !== 1'(pops % 2)) begin
          failures++; $display("FAIL fair_result: got %0d/%b expected %0d/%b", res_data, res_tag, m_data, 1'(pops % 2));
        end
        pops++;
      end
      tick();
    end
    checks++;
    if (pops != 8) begin failures++; $display("FAIL fair_count: got %0d expected 8", pops); end
  endtask

  task automatic test_backpressure();
    int grants, pops;
    grants = 0; pops = 0;
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_ops = OW'($urandom); req1_ops = OW'($urandom);
      predict();
      if (req0_ready === 1'b1 || req1_ready === 1'b1) grants++;
      checks++;
      if (res_valid !== m_rv) begin failures++; $display("FAIL bp_res_valid: got %b expected %b", res_valid, m_rv); end
      tick();
    end
    checks++;
    if (grants != DEPTH) begin failures++; $display("FAIL bp_grants: got %0d expected %0d", grants, DEPTH); end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      predict();
      checks++;
      if (res_valid !== m_rv) begin failures++; $display("FAIL bp_drain_valid: got %b expected %b", res_valid, m_rv); end
      if (m_rv) begin
        pops++;
        checks++;
        if (res_data !== m_data || res_tag !== m_tag) begin
          failures++; $display("FAIL bp_drain_data: got %0d/%b expected %0d/%b", res_data, res_tag, m_data, m_tag);
        end
      end
      tick();
    end
    checks++;
    if (pops != DEPTH) begin failures++; $display("FAIL bp_drain_count: got %0d expected %0d", pops, DEPTH); end
    req0_valid = 1'b1;
    predict();
    checks++;
    if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_resume: got %b expected 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 220; i++) begin
      req0_valid = ($urandom_range(3) != 0); req1_valid = ($urandom_range(3) != 0);
      req0_ops = OW'($urandom); req1_ops = OW'($urandom);
      res_ready = (i < 80) ? 1'b1 : ($urandom_range(3) != 0);
      predict();
      checks++;
      if (req0_ready !== (m_any & ~m_idx) || req1_ready !== (m_any & m_idx)) begin
        failures++; $display("FAIL stream_grant: cycle %0d got %b%b expected %b%b", i, req1_ready, req0_ready, m_any & m_idx, m_any & ~m_idx);
      end
      checks++;
      if ({dp_a, dp_b, dp_c, dp_d, dp_e} !== m_dp) begin
        failures++; $display("FAIL stream_dp: got %h expected %h", {dp_a, dp_b, dp_c, dp_d, dp_e}, m_dp);
      end
      checks++;
      if (res_valid !== m_rv || (m_rv && (res_data !== m_data || res_tag !== m_tag))) begin
        failures++; $display("FAIL stream_result: got %b %0d/%b expected %b %0d/%b", res_valid, res_data, res_tag, m_rv, m_data, m_tag);
      end
      checks++;
      if (busy !== (outstanding != 0)) begin
        failures++; $display("FAIL stream_busy: got %b expected %b", busy, outstanding != 0);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin predict(); tick(); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_ops = OW'($urandom); req1_ops = OW'($urandom);
    predict(); tick();
    req1_valid = 1'b0;
    predict(); tick();
    req0_valid = 1'b0; reset = 1'b1;
    predict(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      predict();
      checks++;
      if (res_valid !== 1'b0) begin failures++; $display("FAIL midflight_res_valid: cycle %0d got %b expected 0", i, res_valid); end
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    predict();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL midflight_prio: got %b%b expected 01", req1_ready, req0_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_ops = '0; req1_ops = '0;
    test_reset();
    test_single(1'b0, 5'd3, 5'd4, 5'd1, 5'd2, 5'd31, 5'd4);
    test_single(1'b1, 5'd1, 5'd1, 5'd3, 5'd3, 5'd31, 5'd28);
    test_single(1'b1, 5'd1, 5'd1, 5'd3, 5'd3, 5'd15, 5'd12);
    test_fairness();
    test_backpressure();
    test_stream();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
